vga_ctrl: RTL and testbench

Raster scan controller between the video framebuffer and the board's VGA pins. It generates 640x480@60 Hz timing from the 50 MHz system clock and drives framebuffer read coordinates. It registers the returned 9-bit pixel into `red`/`green`/`blue`, and aligns `hSync`/`vSync` with the pixels they belong to. The top level instantiates it to drive its `red`, `green`, `blue`, `hSync` and `vSync` outputs.

---
 rtl/vga_ctrl.sv | 101 ++++++++++
 tb/tb_vga_ctrl.sv | 196 +++++++++++++++++++
 2 files changed

// File: rtl/vga_ctrl.sv
// vga_ctrl: 640x480@60 raster timing, framebuffer read coordinates, registered RGB/sync outputs.
// Optional macro VGA_TEST_PATTERN_EN replaces pix_data with internally generated colour bars.
module vga_ctrl #(
  parameter int CLK_DIV  = 2,
  parameter int H_ACTIVE = 640,
  parameter int H_FP     = 16,
  parameter int H_SYNC   = 96,
  parameter int H_BP     = 48,
  parameter int V_ACTIVE = 480,
  parameter int V_FP     = 10,
  parameter int V_SYNC   = 2,
  parameter int V_BP     = 33
) (
  input  logic       clk,
  input  logic       rst,
  output logic [9:0] x_addr,
  output logic [9:0] y_addr,
  input  logic [8:0] pix_data,
  output logic [2:0] red,
  output logic [2:0] green,
  output logic [2:0] blue,
  output logic       hSync,
  output logic       vSync,
  output logic       active,
  output logic       frame_start
);

  localparam int H_TOTAL = H_ACTIVE + H_FP + H_SYNC + H_BP;
  localparam int V_TOTAL = V_ACTIVE + V_FP + V_SYNC + V_BP;
  localparam int DW      = (CLK_DIV > 2) ? $clog2(CLK_DIV) : 1;

  localparam logic [DW-1:0] DIV_LAST = DW'(CLK_DIV - 1);
  localparam logic [9:0]    H_LAST   = 10'(H_TOTAL - 1);
  localparam logic [9:0]    V_LAST   = 10'(V_TOTAL - 1);
  localparam logic [10:0]   H_VIS    = 11'(H_ACTIVE);
  localparam logic [10:0]   V_VIS    = 11'(V_ACTIVE);
  localparam logic [10:0]   HS_BEG   = 11'(H_ACTIVE + H_FP);
  localparam logic [10:0]   HS_END   = 11'(H_ACTIVE + H_FP + H_SYNC);
  localparam logic [10:0]   VS_BEG   = 11'(V_ACTIVE + V_FP);
  localparam logic [10:0]   VS_END   = 11'(V_ACTIVE + V_FP + V_SYNC);

  logic [DW-1:0] div;
  logic [9:0]    h;
  logic [9:0]    v;
  logic          pix_tick;
  logic          vis;
  logic          hs_on;
  logic          vs_on;
  logic [8:0]    col;

  assign pix_tick = (div == DIV_LAST);
  assign x_addr   = h;
  assign y_addr   = v;

  always_comb begin
    vis   = ({1'b0, h} < H_VIS) && ({1'b0, v} < V_VIS);
    hs_on = ({1'b0, h} >= HS_BEG) && ({1'b0, h} < HS_END);
    vs_on = ({1'b0, v} >= VS_BEG) && ({1'b0, v} < VS_END);
`ifdef VGA_TEST_PATTERN_EN
    // Eight 64-pixel bars; bar index bits select full-scale R, G, B.
    col = {{3{h[8]}}, {3{h[7]}}, {3{h[6]}}};
`else
    col = pix_data;
`endif
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      div         <= '0;
      h           <= '0;
      v           <= '0;
      red         <= '0;
      green       <= '0;
      blue        <= '0;
      hSync       <= 1'b1;
      vSync       <= 1'b1;
      active      <= 1'b0;
      frame_start <= 1'b0;
    end else begin
      frame_start <= 1'b0;
      if (pix_tick) begin
        div <= '0;
        if (h == H_LAST) begin
          h <= '0;
          v <= (v == V_LAST) ? 10'd0 : v + 10'd1;
        end else begin
          h <= h + 10'd1;
        end
        // Outputs register the pixel addressed by the counters before they advance.
        {red, green, blue} <= vis ? col : 9'd0;
        hSync       <= ~hs_on;
        vSync       <= ~vs_on;
        active      <= vis;
        frame_start <= (h == 10'd0) && (v == 10'd0);
      end else begin
        div <= div + DW'(1);
      end
    end
  end

endmodule

// File: tb/tb_vga_ctrl.sv
// Bench for vga_ctrl: default-timing instance for line/colour checks, short-frame instance for frame-level checks.
module tb_vga_ctrl;

  logic clk = 1'b0;
  always #10 clk = ~clk;

  // Instance A: default 640x480 timing, pix_data from constant or 1-clock-latency RAM model
  logic       rst_a;
  logic [9:0] x_a, y_a;
  logic [8:0] pix_a, ram_q, pd_const;
  logic       pd_mode;
  logic [2:0] r_a, g_a, b_a;
  logic       hs_a, vs_a, act_a, fs_a;
  int         cyc_a;

  // Instance B: default horizontal timing, 8-line frame so frame-level events fit a short run
  logic       rst_b;
  logic [9:0] x_b, y_b;
  logic [2:0] r_b, g_b, b_b;
  logic       hs_b, vs_b, act_b, fs_b;
  int         cyc_b;

  int errors = 0;
  int checks = 0;

  assign pix_a = pd_mode ? ram_q : pd_const;

  always @(posedge clk) begin
    ram_q <= x_a[8:0];
    cyc_a <= rst_a ? 0 : cyc_a + 1;
    cyc_b <= rst_b ? 0 : cyc_b + 1;
  end

  vga_ctrl dut_a (
    .clk(clk), .rst(rst_a), .x_addr(x_a), .y_addr(y_a), .pix_data(pix_a),
    .red(r_a), .green(g_a), .blue(b_a), .hSync(hs_a), .vSync(vs_a),
    .active(act_a), .frame_start(fs_a)
  );

  vga_ctrl #(.V_ACTIVE(4), .V_FP(1), .V_SYNC(2), .V_BP(1)) dut_b (
    .clk(clk), .rst(rst_b), .x_addr(x_b), .y_addr(y_b), .pix_data(9'h1FF),
    .red(r_b), .green(g_b), .blue(b_b), .hSync(hs_b), .vSync(vs_b),
    .active(act_b), .frame_start(fs_b)
  );

  typedef struct {
    logic [8:0] pd;
    int         k;
    logic [8:0] rgb;
    logic       act;
    logic       hs;
    logic       fs;
  } vec_t;

  vec_t tbl[9];

  task automatic chk(input string name, input int got, input int exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, got, exp);
    end
  endtask

  task automatic wait_a(input int t);
    int n = 0;
    while (cyc_a != t && n < 20000) begin
      @(negedge clk);
      n++;
    end
    if (cyc_a != t) chk("timeout_a", cyc_a, t);
  endtask

  task automatic wait_b(input int t);
    int n = 0;
    while (cyc_b != t && n < 20000) begin
      @(negedge clk);
      n++;
    end
    if (cyc_b != t) chk("timeout_b", cyc_b, t);
  endtask

  task automatic wait_hs_a(input logic lvl, output int c);
    int n = 0;
    while (hs_a !== lvl && n < 5000) begin
      @(negedge clk);
      n++;
    end
    c = cyc_a;
  endtask

  // Expected colour at visible column k of a visible line for framebuffer value pd
  function automatic logic [8:0] exp_col(input int k, input logic [8:0] pd);
    logic [9:0] kk;
    kk = 10'(k);
    if (k >= 640) return 9'd0;
`ifdef VGA_TEST_PATTERN_EN
    return {{3{kk[8]}}, {3{kk[7]}}, {3{kk[6]}}};
`else
    return pd;
`endif
  endfunction

  initial begin
    int c;
    tbl[0] = '{9'h1FF,          0, 9'h1FF, 1'b1, 1'b1, 1'b1};
    tbl[1] = '{9'b101_010_011,  5, 9'h153, 1'b1, 1'b1, 1'b0};
    tbl[2] = '{9'h0AA,        639, 9'h0AA, 1'b1, 1'b1, 1'b0};
    tbl[3] = '{9'h1FF,        640, 9'h000, 1'b0, 1'b1, 1'b0};
    tbl[4] = '{9'h1FF,        655, 9'h000, 1'b0, 1'b1, 1'b0};
    tbl[5] = '{9'h1FF,        656, 9'h000, 1'b0, 1'b0, 1'b0};
    tbl[6] = '{9'h1FF,        751, 9'h000, 1'b0, 1'b0, 1'b0};
    tbl[7] = '{9'h1FF,        752, 9'h000, 1'b0, 1'b1, 1'b0};
    tbl[8] = '{9'h1FF,        799, 9'h000, 1'b0, 1'b1, 1'b0};

    rst_a = 1'b1; rst_b = 1'b1; pd_mode = 1'b0; pd_const = 9'h1FF;
    repeat (50) @(negedge clk);
    chk("rst_rgb",  {r_a, g_a, b_a}, 0);
    chk("rst_hs",   hs_a, 1);
    chk("rst_vs",   vs_a, 1);
    chk("rst_act",  act_a, 0);
    chk("rst_fs",   fs_a, 0);
    chk("rst_addr", {x_a, y_a}, 0);

    rst_a = 1'b0;
    wait_a(1);
    chk("pre_tick_act", act_a, 0);
    chk("pre_tick_fs",  fs_a, 0);

    for (int i = 0; i < 9; i++) begin
      pd_const = tbl[i].pd;
      wait_a(2 + 2 * tbl[i].k);
      chk($sformatf("vec%0d_rgb", i), {r_a, g_a, b_a}, exp_col(tbl[i].k, tbl[i].rgb));
      chk($sformatf("vec%0d_act", i), act_a, tbl[i].act);
      chk($sformatf("vec%0d_hs", i),  hs_a, tbl[i].hs);
      chk($sformatf("vec%0d_vs", i),  vs_a, 1);
      chk($sformatf("vec%0d_fs", i),  fs_a, tbl[i].fs);
    end

    // Second line: hSync period and width
    pd_const = 9'h1FF;
    wait_hs_a(1'b0, c);
    chk("hs_fall_line1", c, 1314 + 1600);
    wait_hs_a(1'b1, c);
    chk("hs_rise_line1", c, 1314 + 1600 + 192);

    // Framebuffer RAM model over all of line 0
    rst_a = 1'b1;
    @(negedge clk);
    pd_mode = 1'b1;
    rst_a = 1'b0;
    for (int k = 0; k < 800; k++) begin
      wait_a(2 + 2 * k);
      chk($sformatf("ram_rgb_h%0d", k), {r_a, g_a, b_a}, exp_col(k, 9'(k)));
      chk($sformatf("ram_act_h%0d", k), act_a, (k < 640) ? 1 : 0);
    end

    // Instance B: frame_start, vSync, mid-frame reset
    rst_b = 1'b0;
    wait_b(1);  chk("b_fs_c1", fs_b, 0);
    wait_b(2);  chk("b_fs_c2", fs_b, 1);
    wait_b(3);  chk("b_fs_c3", fs_b, 0);
    wait_b(8000);  chk("b_vs_before", vs_b, 1);
    wait_b(8002);  chk("b_vs_fall", vs_b, 0);
    wait_b(11200); chk("b_vs_held", vs_b, 0);
    wait_b(11202); chk("b_vs_rise", vs_b, 1);
    wait_b(12801); chk("b_fs_pre2", fs_b, 0);
    wait_b(12802); chk("b_fs_frame2", fs_b, 1);
    wait_b(12803); chk("b_fs_post2", fs_b, 0);
    wait_b(12802 + 2 * (1600 + 300));
    chk("b_mid_act", act_b, 1);
    chk("b_mid_rgb", {r_b, g_b, b_b}, exp_col(300, 9'h1FF));

    rst_b = 1'b1;
    @(negedge clk);
    chk("b_rst_rgb",  {r_b, g_b, b_b}, 0);
    chk("b_rst_act",  act_b, 0);
    chk("b_rst_sync", {hs_b, vs_b}, 2'b11);
    chk("b_rst_fs",   fs_b, 0);
    chk("b_rst_addr", {x_b, y_b}, 0);
    rst_b = 1'b0;
    begin
      int n = 0;
      while (hs_b !== 1'b0 && n < 5000) begin
        @(negedge clk);
        n++;
      end
    end
    chk("b_hs_fall_after_rst", cyc_b, 1314);
    chk("b_vs_after_rst", vs_b, 1);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
